// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the EX-side multi-cycle divider.
// Holds state encodings plus the one-step restoring-division datapath.
package div_unit_pkg;

    localparam int RegWidth       = 32;
    localparam int DoubleRegWidth = 64;
    localparam int DivStateWidth  = 2;
    localparam int DivCntWidth    = 5;

    typedef enum logic [DivStateWidth-1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Partial remainder carries one guard bit so the trial subtraction sign is visible.
    typedef struct packed {
        logic [RegWidth:0]   rem;
        logic [RegWidth-1:0] quo;
    } div_part_t;

    function automatic logic [RegWidth-1:0] cond_neg(input logic [RegWidth-1:0] v,
                                                     input logic             neg);
        cond_neg = neg ? (~v + 32'd1) : v;
    endfunction

    function automatic div_part_t div_step(input div_part_t           cur,
                                           input logic [RegWidth-1:0] dvs);
        div_part_t           nxt;
        logic [RegWidth:0]   shifted;
        logic [RegWidth:0]   diff;
        shifted = {cur.rem[RegWidth-1:0], cur.quo[RegWidth-1]};
        diff    = shifted - {1'b0, dvs};
        nxt.quo = {cur.quo[RegWidth-2:0], 1'b0};
        if (!diff[RegWidth]) begin
            nxt.rem    = diff;
            nxt.quo[0] = 1'b1;
        end else begin
            nxt.rem = shifted;
        end
        div_step = nxt;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider beside EX; returns {remainder, quotient}
// 33 cycles after start (1 cycle for a zero divisor), with a one-cycle done strobe.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = RegWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   div_data1_i,
    input  logic [DATA_WIDTH-1:0]   div_data2_i,
    input  logic                    div_signed_i,
    input  logic                    div_start_i,
    input  logic                    div_cancel_i,
    output logic [2*DATA_WIDTH-1:0] div_result_o,
    output logic                    div_done_o
);

    div_state_e              state_q, state_d;
    logic [DivCntWidth-1:0]  cnt_q, cnt_d;
    div_part_t               part_q, part_d;
    logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
    logic                    neg_quo_q, neg_quo_d;
    logic                    neg_rem_q, neg_rem_d;
    logic [2*DATA_WIDTH-1:0] result_q, result_d;
    logic                    done_q, done_d;
    div_part_t               step_s;
    logic                    d1_neg_s;
    logic                    d2_neg_s;

    assign step_s   = div_step(part_q, dvs_q);
    assign d1_neg_s = div_signed_i & div_data1_i[DATA_WIDTH-1];
    assign d2_neg_s = div_signed_i & div_data2_i[DATA_WIDTH-1];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        if (div_cancel_i) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_start_i) begin
                        dvs_d     = cond_neg(div_data2_i, d2_neg_s);
                        neg_quo_d = d1_neg_s ^ d2_neg_s;
                        neg_rem_d = d1_neg_s;
                        if (div_data2_i == {DATA_WIDTH{1'b0}}) begin
                            // Zero divisor: all-ones quotient, raw dividend as remainder.
                            state_d  = DIV_DONE;
                            result_d = {div_data1_i, {DATA_WIDTH{1'b1}}};
                            done_d   = 1'b1;
                        end else begin
                            state_d    = DIV_BUSY;
                            cnt_d      = {DivCntWidth{1'b0}};
                            part_d.rem = {(DATA_WIDTH+1){1'b0}};
                            part_d.quo = cond_neg(div_data1_i, d1_neg_s);
                        end
                    end else begin
                        state_d = DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    part_d = step_s;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                        result_d = {cond_neg(step_s.rem[DATA_WIDTH-1:0], neg_rem_q),
                                    cond_neg(step_s.quo, neg_quo_q)};
                    end else begin
                        state_d = DIV_BUSY;
                    end
                end
                DIV_DONE: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= {DivCntWidth{1'b0}};
            part_q    <= '0;
            dvs_q     <= {DATA_WIDTH{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {(2*DATA_WIDTH){1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign div_result_o = result_q;
    assign div_done_o   = done_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with hand-computed expectations.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        sg;
    logic        start;
    logic        cancel;
    logic [63:0] result;
    logic        done;

    int n_cmp;
    int n_err;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_data1_i  (d1),
        .div_data2_i  (d2),
        .div_signed_i (sg),
        .div_start_i  (start),
        .div_cancel_i (cancel),
        .div_result_o (result),
        .div_done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Starts one operation, holds start until done, checks latency, result, strobe width and hold.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp, input int exp_lat,
                           input bit scramble);
        int n;
        bit seen;
        @(negedge clk);
        d1 = a; d2 = b; sg = sgn; start = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (done) begin
                seen = 1'b1;
            end else if (scramble && n == 5) begin
                d1 = ~a; d2 = 32'd3; sg = ~sgn;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " result"}, result, exp);
        @(posedge clk);
        #1;
        chk({tag, " done one cycle"}, {63'd0, done}, 64'd0);
        chk({tag, " result hold"}, result, exp);
    endtask

    initial begin
        int dcount;
        n_cmp = 0; n_err = 0;
        rst = 1'b0; d1 = 32'd0; d2 = 32'd0; sg = 1'b0; start = 1'b0; cancel = 1'b0;
        #12;
        chk("reset result", result, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("u 7/2",        32'd7,        32'd2,        1'b0, {32'd1, 32'd3},                 33, 1'b0);
        run_div("s -7/2",       32'hFFFFFFF9, 32'd2,        1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},   33, 1'b0);
        run_div("s 7/-2",       32'd7,        32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD},   33, 1'b0);
        run_div("s ovf",        32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000},   33, 1'b0);
        run_div("u big/16",     32'hFFFFFFFF, 32'h10,       1'b0, {32'h0000000F, 32'h0FFFFFFF},   33, 1'b0);
        run_div("s div0",       32'h12345678, 32'd0,        1'b1, {32'h12345678, 32'hFFFFFFFF},   1,  1'b0);
        run_div("u div0",       32'h12345678, 32'd0,        1'b0, {32'h12345678, 32'hFFFFFFFF},   1,  1'b0);

        // Cancel partway through BUSY: no done may appear afterwards.
        @(negedge clk);
        d1 = 32'd100; d2 = 32'd7; sg = 1'b0; start = 1'b1;
        repeat (11) @(negedge clk);
        cancel = 1'b1; start = 1'b0;
        @(negedge clk);
        cancel = 1'b0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("cancel no done", 64'(dcount), 64'd0);
        run_div("u 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 1'b0);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        d1 = 32'd1000; d2 = 32'd3; sg = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async rst result", result, 64'd0);
        chk("async rst done", {63'd0, done}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("post rst no done", 64'(dcount), 64'd0);
        run_div("u 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b0);

        // Operand inputs wiggle during BUSY; the latched values must win.
        run_div("u 50/5 scramble", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33, 1'b1);
        run_div("s -50/7 scramble", 32'hFFFFFFCE, 32'd7, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFF9}, 33, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
